// File: rtl/gemm_pkg.sv
// Shared definitions for the gemm datapath: selector codes, accumulator FSM states
// and the selector validity check.
package gemm_pkg;

  localparam logic [2:0] SEL_GEMM1X16X1_W64 = 3'b001;
  localparam logic [2:0] SEL_GEMM1X32X1_W64 = 3'b010;
  localparam logic [2:0] SEL_GEMM1X4X1_W64  = 3'b011;
  localparam logic [2:0] SEL_GEMM1X8X1_W64  = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

  // True for the four selector codes that map to a real gemm mode.
  function automatic logic sel_valid(logic [2:0] sel);
    logic ok;
    case (sel)
      SEL_GEMM1X16X1_W64,
      SEL_GEMM1X32X1_W64,
      SEL_GEMM1X4X1_W64,
      SEL_GEMM1X8X1_W64: ok = 1'b1;
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/gemm_accumulator_if.sv
// Beat input and result output handshake bundle of the gemm accumulation stage.
// master: the producer/consumer side, slave: the accumulator.
interface gemm_accumulator_if #(
  parameter int unsigned ACC_W = 48,
  parameter int unsigned CNT_W = 9
);
  logic [2:0]       bin_selector_EX;
  logic [63:0]      dp_in;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic [2:0]       out_mode;
  logic [CNT_W-1:0] out_beats;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output bin_selector_EX, dp_in, in_valid, in_last, out_ready,
    input  in_ready, acc_out, out_mode, out_beats, out_err, out_valid
  );

  modport slave (
    input  bin_selector_EX, dp_in, in_valid, in_last, out_ready,
    output in_ready, acc_out, out_mode, out_beats, out_err, out_valid
  );
endinterface

// File: rtl/acc_sat_adder.sv
// Combinational ACC_W-bit two's complement adder.
// Build option GEMM_ACC_SAT_EN: clamp to the signed range on overflow and raise ovf.
// Without it the sum wraps and ovf stays low.
module acc_sat_adder #(
  parameter int unsigned ACC_W = 48
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W-1:0] raw;

  assign raw = a + b;

`ifdef GEMM_ACC_SAT_EN
  logic raw_ovf;

  // Overflow only when both operands share a sign the result does not.
  assign raw_ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

  // Clamp towards the operands' sign.
  always_comb begin
    sum = raw;
    ovf = raw_ovf;
    if (raw_ovf) begin
      sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = raw;
  assign ovf = 1'b0;
`endif
endmodule

// File: rtl/gemm_accumulator.sv
// Sums the 64-bit gemm partial products of a beat group and returns one result per group.
// Build option GEMM_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module gemm_accumulator
  import gemm_pkg::*;
#(
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input logic               clk,
  input logic               rst,
  gemm_accumulator_if.slave bus
);
  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic [2:0]       mode_q, mode_d;
  logic             err_q, err_d;

  logic             accept, first, sel_ok, at_max, close;
  logic [ACC_W-1:0] add_a, addend, sum;
  logic             ovf;

  // The running registers double as the result registers: in HOLD no beat is accepted
  // unless the result is taken in the same cycle, so they are stable while out_valid is high.
  assign bus.in_ready  = (state_q != HOLD) || bus.out_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.acc_out   = acc_q;
  assign bus.out_mode  = mode_q;
  assign bus.out_beats = cnt_q;
  assign bus.out_err   = err_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign first    = (state_q != ACCUM);
  assign sel_ok   = sel_valid(bus.bin_selector_EX);
  assign addend   = sel_ok ? bus.dp_in[ACC_W-1:0] : '0;
  assign add_a    = first ? '0 : acc_q;
  assign cnt_next = first ? {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q + 1'b1;
  assign at_max   = (cnt_next == CNT_W'(MAX_BEATS));
  assign close    = bus.in_last || at_max;

  if (ACC_W < 64) begin : g_dp_hi
    logic unused_dp_hi;
    assign unused_dp_hi = ^bus.dp_in[63:ACC_W];
  end

  acc_sat_adder #(
    .ACC_W(ACC_W)
  ) u_adder (
    .a  (add_a),
    .b  (addend),
    .sum(sum),
    .ovf(ovf)
  );

  // Next-state and group bookkeeping.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    if (accept) begin
      acc_d   = sum;
      cnt_d   = cnt_next;
      mode_d  = first ? bus.bin_selector_EX : mode_q;
      err_d   = (!first && err_q) || !sel_ok || ovf || (at_max && !bus.in_last) ||
                (!first && (bus.bin_selector_EX != mode_q));
      state_d = close ? HOLD : ACCUM;
    end else begin
      case (state_q)
        HOLD:    if (bus.out_ready) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // State and group registers; reset drops any open group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_gemm_accumulator.sv
// Scoreboard bench for gemm_accumulator: a driver feeds beats and a group-level model
// queues expected results; a consumer process pops and compares on each handshake.
module tb_gemm_accumulator;
  localparam int unsigned ACC_W     = 36;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);
  localparam longint      MAXV      = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint      MINV      = -MAXV - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gemm_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  gemm_accumulator #(
    .ACC_W    (ACC_W),
    .MAX_BEATS(MAX_BEATS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic [2:0]       mode;
    int               beats;
    logic             err;
  } res_t;

  res_t        exp_q[$];
  logic [2:0]  g_sel[$];
  logic [63:0] g_val[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          outstanding = 0;
  int          rdy_mode = 1;
  int          stall_left = 0;
  bit          started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [63:0] v);
    logic signed [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return longint'(t);
  endfunction

  // Group result from the list of beats, straight from the arithmetic rules.
  function automatic res_t model(input bit last);
    res_t   r;
    longint acc;
    bit     err;
    bit     ok;
    acc     = 0;
    err     = 0;
    r.mode  = g_sel[0];
    r.beats = g_sel.size();
    for (int i = 0; i < g_sel.size(); i++) begin
      ok = (g_sel[i] >= 3'd1) && (g_sel[i] <= 3'd4);
      if (!ok || g_sel[i] != r.mode) err = 1;
      if (i == 0) acc = ok ? sx(g_val[i]) : 0;
      else begin
        acc = acc + (ok ? sx(g_val[i]) : 0);
`ifdef GEMM_ACC_SAT_EN
        if (acc > MAXV) begin acc = MAXV; err = 1; end
        else if (acc < MINV) begin acc = MINV; err = 1; end
`else
        acc = sx(acc);
`endif
      end
    end
    if (r.beats == MAX_BEATS && !last) err = 1;
    r.acc = acc[ACC_W-1:0];
    r.err = err;
    return r;
  endfunction

  task automatic accept_model(input logic [2:0] sel, input logic [63:0] val, input bit last);
    g_sel.push_back(sel);
    g_val.push_back(val);
    if (last || g_sel.size() == MAX_BEATS) begin
      exp_q.push_back(model(last));
      outstanding++;
      g_sel.delete();
      g_val.delete();
    end
  endtask

  task automatic send_beat(input logic [2:0] sel, input logic [63:0] val, input bit last);
    bit done;
    done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      bus.in_valid        = 1'b1;
      bus.bin_selector_EX = sel;
      bus.dp_in           = val;
      bus.in_last         = last;
      #3;
      chk("in_ready", 64'(bus.in_ready), 64'(outstanding == 0 || bus.out_ready));
      done = bus.in_ready;
      @(posedge clk);
      if (done) accept_model(sel, val, last);
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: beat not accepted within 100 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while ((outstanding != 0 || exp_q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 64'(outstanding + exp_q.size()), 64'(0));
  endtask

  // Consumer and scoreboard checker.
  initial begin : consumer
    res_t r;
    bus.out_ready = 1'b0;
    wait (started);
    forever begin
      @(negedge clk);
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else if (rdy_mode == 1) bus.out_ready = 1'b1;
      else bus.out_ready = ($urandom_range(0, 3) != 0);
      #2;
      chk("out_valid", 64'(bus.out_valid), 64'(outstanding > 0));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: acc %0h with no expected group", bus.acc_out);
        end else begin
          r = exp_q.pop_front();
          chk("acc_out", 64'(bus.acc_out), 64'(r.acc));
          chk("out_mode", 64'(bus.out_mode), 64'(r.mode));
          chk("out_beats", 64'(bus.out_beats), 64'(r.beats));
          chk("out_err", 64'(bus.out_err), 64'(r.err));
        end
        @(posedge clk);
        if (outstanding > 0) outstanding--;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [2:0]  cur_mode;
    logic [2:0]  sel;
    logic [63:0] val;
    bus.in_valid        = 1'b0;
    bus.in_last         = 1'b0;
    bus.dp_in           = '0;
    bus.bin_selector_EX = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_acc_out", 64'(bus.acc_out), 64'(0));
    chk("rst_out_mode", 64'(bus.out_mode), 64'(0));
    chk("rst_out_beats", 64'(bus.out_beats), 64'(0));
    chk("rst_out_err", 64'(bus.out_err), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    started = 1;

    // Basic 3-beat group.
    send_beat(3'b010, 64'd5, 0);
    send_beat(3'b010, 64'd7, 0);
    send_beat(3'b010, -64'sd2, 1);
    drain();

    // Single-beat groups against a stalled consumer.
    stall_left = 4;
    send_beat(3'b001, 64'd100, 1);
    send_beat(3'b001, 64'd200, 1);
    drain();

    // Mode change mid-group, then a clean group.
    send_beat(3'b100, 64'd1, 0);
    send_beat(3'b100, 64'd1, 0);
    send_beat(3'b011, 64'd1, 1);
    send_beat(3'b100, 64'd6, 0);
    send_beat(3'b100, 64'd7, 1);
    drain();

    // Invalid selector contributes nothing but is counted.
    send_beat(3'b000, 64'd50, 0);
    send_beat(3'b001, 64'd4, 1);
    drain();

    // Forced close on the MAX_BEATS-th beat; the next beat opens a new group.
    repeat (4) send_beat(3'b001, 64'd1, 0);
    send_beat(3'b001, 64'd9, 1);
    drain();

    // Overflow: saturates or wraps depending on the build.
    send_beat(3'b001, 64'd1 << 34, 0);
    send_beat(3'b001, 64'd1 << 34, 0);
    send_beat(3'b001, 64'd1 << 34, 1);
    drain();

    // Reset mid-group discards the open group.
    send_beat(3'b010, 64'd3, 0);
    send_beat(3'b010, 64'd3, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    g_sel.delete();
    g_val.delete();
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    idle(3);
    send_beat(3'b010, 64'd8, 1);
    drain();

    // Randomized traffic with random consumer back-pressure.
    rdy_mode = 0;
    cur_mode = 3'b001;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else begin
        if (g_sel.size() == 0) cur_mode = 3'($urandom_range(1, 4));
        sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : cur_mode;
        if ($urandom_range(0, 1) == 0) val = {$urandom, $urandom};
        else val = 64'(longint'($urandom_range(0, 2000)) - 1000);
        send_beat(sel, val, $urandom_range(0, 2) == 0);
      end
    end
    rdy_mode = 1;
    if (g_sel.size() != 0) send_beat(cur_mode, 64'd1, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
